// File: rtl/pipelined_adder.sv
// Segmented ripple adder: one SEG_WIDTH slice of a+b+cin per register stage, with carry and signed overflow.
// Latency STAGES cycles from input transfer to out_valid; one result per cycle when unstalled.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready (no in_valid -> in_ready path).
module pipelined_adder #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SEG_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int unsigned STAGES = (SEG_WIDTH >= 1) ? (WIDTH / SEG_WIDTH) : 1;

    if ((SEG_WIDTH < 1) || (WIDTH < SEG_WIDTH) || ((WIDTH % SEG_WIDTH) != 0)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a non-zero multiple of SEG_WIDTH");
    end

    logic stall;
    logic advance;

    // The whole pipe moves in lockstep, so a single stall term gates every stage.
    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO   = k * SEG_WIDTH;
        localparam int unsigned HI   = WIDTH - LO;
        localparam bit          LAST = (k == STAGES - 1);

        logic [HI-1:0]           a_src;
        logic [HI-1:0]           b_src;
        logic                    c_src;
        logic                    v_src;
        logic [SEG_WIDTH:0]      seg;
        logic [LO+SEG_WIDTH-1:0] sum_d;
        logic [LO+SEG_WIDTH-1:0] sum_q;
        logic                    cry_d;
        logic                    cry_q;
        logic                    vld_d;
        logic                    vld_q;

        if (k == 0) begin : g_src
            assign a_src = a;
            assign b_src = b;
            assign c_src = cin;
            assign v_src = in_valid;
            assign sum_d = seg[SEG_WIDTH-1:0];
        end else begin : g_src
            assign a_src = g_stage[k-1].g_up.a_q;
            assign b_src = g_stage[k-1].g_up.b_q;
            assign c_src = g_stage[k-1].cry_q;
            assign v_src = g_stage[k-1].vld_q;
            assign sum_d = {seg[SEG_WIDTH-1:0], g_stage[k-1].sum_q};
        end

        // Remaining operand bits arrive right-aligned, so this stage's slice is always the low bits.
        assign seg   = {1'b0, a_src[SEG_WIDTH-1:0]} + {1'b0, b_src[SEG_WIDTH-1:0]}
                     + {{SEG_WIDTH{1'b0}}, c_src};
        assign cry_d = seg[SEG_WIDTH];
        assign vld_d = v_src;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                cry_q <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                vld_q <= vld_d;
                cry_q <= cry_d;
                sum_q <= sum_d;
            end
        end

        if (!LAST) begin : g_up
            logic [HI-SEG_WIDTH-1:0] a_d;
            logic [HI-SEG_WIDTH-1:0] b_d;
            logic [HI-SEG_WIDTH-1:0] a_q;
            logic [HI-SEG_WIDTH-1:0] b_q;

            assign a_d = a_src[HI-1:SEG_WIDTH];
            assign b_d = b_src[HI-1:SEG_WIDTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB's own sum bit: c_in = a ^ b ^ s.
            assign ovf_d = (a_src[HI-1] ^ b_src[HI-1] ^ seg[SEG_WIDTH-1]) ^ seg[SEG_WIDTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign carry     = g_stage[STAGES-1].cry_q;
    assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder at 16/4, 8/8 and 32/8 geometries.
module tb_pipelined_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry;
    logic        overflow;

    logic        sw_vld;
    logic        sw_ordy;
    logic        sw_cin;
    logic [7:0]  a8, b8, s8_sum;
    logic        s8_in_ready, s8_out_valid, s8_carry, s8_ovf;
    logic [31:0] a32, b32, s32_sum;
    logic        s32_in_ready, s32_out_valid, s32_carry, s32_ovf;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int ndeliv = 0;
    logic        chk_lat = 1'b1;
    logic        stall_prev = 1'b0;
    logic [33:0] held;
    logic [33:0] nxt16, nxt8, nxt32;
    logic [33:0] q16[$], q8[$], q32[$];
    int          t16[$], t8[$], t32[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .SEG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow)
    );

    pipelined_adder #(.WIDTH(8), .SEG_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(sw_vld), .in_ready(s8_in_ready),
        .a(a8), .b(b8), .cin(sw_cin), .out_valid(s8_out_valid), .out_ready(sw_ordy),
        .sum(s8_sum), .carry(s8_carry), .overflow(s8_ovf)
    );

    pipelined_adder #(.WIDTH(32), .SEG_WIDTH(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(sw_vld), .in_ready(s32_in_ready),
        .a(a32), .b(b32), .cin(sw_cin), .out_valid(s32_out_valid), .out_ready(sw_ordy),
        .sum(s32_sum), .carry(s32_carry), .overflow(s32_ovf)
    );

    // Reference: one full-width add, overflow from sign bits of operands and result.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input int w);
        logic [31:0] mask;
        logic [32:0] full;
        logic [31:0] s;
        logic        co;
        logic        cm;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {1'b0, x & mask} + {1'b0, y & mask} + {32'd0, ci};
        s    = full[31:0] & mask;
        co   = full[w];
        cm   = x[w-1] ^ y[w-1] ^ s[w-1];
        return {cm ^ co, co, s};
    endfunction

    function automatic logic [33:0] pk(input logic ov, input logic c, input logic [31:0] s);
        return {ov, c, s};
    endfunction

    function automatic logic [33:0] cur16();
        return {overflow, carry, 16'h0000, sum};
    endfunction

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample at posedge+3, score transfers, advance to posedge+1.
    task automatic cycle(output logic acc);
        logic dlv;
        #2;
        check("in_ready", {33'b0, in_ready}, {33'b0, ~(out_valid & ~out_ready)});
        if (stall_prev) begin
            check("stall_valid", {33'b0, out_valid}, 34'd1);
            check("stall_hold", cur16(), held);
        end
        acc = in_valid & in_ready;
        dlv = out_valid & out_ready;
        if (dlv) begin
            ndeliv++;
            if (q16.size() == 0) begin
                check("spurious16", {33'b0, out_valid}, 34'd0);
            end else begin
                check("result16", cur16(), q16[0]);
                if (chk_lat) check("latency16", 34'(cyc - t16[0]), 34'd4);
                void'(q16.pop_front());
                void'(t16.pop_front());
            end
        end
        if (acc) begin
            q16.push_back(nxt16);
            t16.push_back(cyc);
        end
        if (sw_vld) begin
            check("in_ready8", {33'b0, s8_in_ready}, 34'd1);
            check("in_ready32", {33'b0, s32_in_ready}, 34'd1);
        end
        if (s8_out_valid) begin
            if (q8.size() == 0) begin
                check("spurious8", {33'b0, s8_out_valid}, 34'd0);
            end else begin
                check("result8", {s8_ovf, s8_carry, 24'h0, s8_sum}, q8[0]);
                check("latency8", 34'(cyc - t8[0]), 34'd1);
                void'(q8.pop_front());
                void'(t8.pop_front());
            end
        end
        if (s32_out_valid) begin
            if (q32.size() == 0) begin
                check("spurious32", {33'b0, s32_out_valid}, 34'd0);
            end else begin
                check("result32", {s32_ovf, s32_carry, s32_sum}, q32[0]);
                check("latency32", 34'(cyc - t32[0]), 34'd4);
                void'(q32.pop_front());
                void'(t32.pop_front());
            end
        end
        if (sw_vld & s8_in_ready) begin
            q8.push_back(nxt8);
            t8.push_back(cyc);
        end
        if (sw_vld & s32_in_ready) begin
            q32.push_back(nxt32);
            t32.push_back(cyc);
        end
        stall_prev = out_valid & ~out_ready;
        held = cur16();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int n);
        logic acc;
        for (int i = 0; i < n && (q16.size() != 0 || q8.size() != 0 || q32.size() != 0); i++) begin
            cycle(acc);
        end
        check("drain_left", 34'(q16.size() + q8.size() + q32.size()), 34'd0);
    endtask

    task automatic single(input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic [33:0] exp);
        logic acc;
        a = x; b = y; cin = ci;
        nxt16 = exp;
        in_valid = 1'b1;
        chk_lat = 1'b1;
        cycle(acc);
        check("single_accept", {33'b0, acc}, 34'd1);
        in_valid = 1'b0;
        drain(20);
    endtask

    initial begin
        logic acc;
        int   issued;
        int   d0;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        sw_vld = 1'b0; sw_ordy = 1'b1; sw_cin = 1'b0; a8 = '0; b8 = '0; a32 = '0; b32 = '0;
        nxt16 = '0; nxt8 = '0; nxt32 = '0; held = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("rst_out_valid", {33'b0, out_valid}, 34'd0);
        check("rst_sum", {18'b0, sum}, 34'd0);
        check("rst_carry", {33'b0, carry}, 34'd0);
        check("rst_overflow", {33'b0, overflow}, 34'd0);
        check("rst_in_ready", {33'b0, in_ready}, 34'd1);
        @(posedge clk); #1;

        single(16'hFFFF, 16'h0001, 1'b0, pk(1'b0, 1'b1, 32'h0000_0000));
        single(16'h7FFF, 16'h0001, 1'b0, pk(1'b1, 1'b0, 32'h0000_8000));
        single(16'h8000, 16'h8000, 1'b1, pk(1'b1, 1'b1, 32'h0000_0001));

        // Back-to-back random stream on all three geometries at once.
        d0 = ndeliv;
        chk_lat = 1'b1; out_ready = 1'b1; in_valid = 1'b1; sw_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); a32 = $urandom; b32 = $urandom;
            sw_cin = 1'($urandom);
            nxt16 = model({16'h0, a}, {16'h0, b}, cin, 16);
            nxt8  = model({24'h0, a8}, {24'h0, b8}, sw_cin, 8);
            nxt32 = model(a32, b32, sw_cin, 32);
            cycle(acc);
        end
        in_valid = 1'b0; sw_vld = 1'b0;
        drain(20);
        check("stream_count", 34'(ndeliv - d0), 34'd100);

        // Eight ops with out_ready dropped for five cycles mid-stream.
        chk_lat = 1'b0; issued = 0; d0 = ndeliv;
        for (int t = 0; t < 60 && (issued < 8 || q16.size() != 0); t++) begin
            out_ready = !(t >= 4 && t < 9);
            in_valid = (issued < 8);
            a = 16'(16'h1111 * (issued + 1));
            b = 16'(16'h0F0F ^ (16'h0123 * issued));
            cin = issued[0];
            nxt16 = model({16'h0, a}, {16'h0, b}, cin, 16);
            cycle(acc);
            if (acc) issued++;
        end
        check("bp_count", 34'(ndeliv - d0), 34'd8);

        // Random in_valid / out_ready toggling.
        issued = 0; d0 = ndeliv;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        nxt16 = model({16'h0, a}, {16'h0, b}, cin, 16);
        for (int t = 0; t < 600 && (issued < 40 || q16.size() != 0); t++) begin
            in_valid = (issued < 40) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
            if (acc) begin
                issued++;
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
                nxt16 = model({16'h0, a}, {16'h0, b}, cin, 16);
            end
        end
        check("rand_count", 34'(ndeliv - d0), 34'd40);

        // Reset with three results in flight: none may ever emerge.
        out_ready = 1'b1; in_valid = 1'b1; chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'(16'h0A0A + i); b = 16'(16'h00F0 * (i + 1)); cin = 1'b1;
            nxt16 = model({16'h0, a}, {16'h0, b}, cin, 16);
            cycle(acc);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        cyc++;
        #1 rst = 1'b0;
        q16.delete(); t16.delete();
        stall_prev = 1'b0;
        #2;
        check("midrst_out_valid", {33'b0, out_valid}, 34'd0);
        check("midrst_in_ready", {33'b0, in_ready}, 34'd1);
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("flushed", {33'b0, out_valid}, 34'd0);
            cycle(acc);
        end
        single(16'h1234, 16'h4321, 1'b1, pk(1'b0, 1'b0, 32'h0000_5556));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
